// File: rtl/conv_result_drain_if.sv
// Output stream of conv_result_drain: one FP16 result word per beat, with its
// tile coordinates.
//   valid : data/x/y/last hold a word            (master -> slave)
//   ready : consumer accepts the word            (slave -> master)
//   data  : result word, DATA_WIDTH bits         (master -> slave)
//   x, y  : column/row of the word in the tile   (master -> slave)
//   last  : final word of the tile               (master -> slave)
interface conv_result_drain_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [IDX_WIDTH-1:0]  x;
  logic [IDX_WIDTH-1:0]  y;
  logic                  last;

  modport master (
    output valid,
    output data,
    output x,
    output y,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  x,
    input  y,
    input  last,
    output ready
  );
endinterface

// File: rtl/conv_result_drain.sv
// Result drain for the parallel FP16 convolver. Each rising edge of in_ready
// captures a PARA_X x PARA_Y tile (optionally ReLU'd) into one of two ping-pong
// banks; the oldest full bank is streamed out one word per beat.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_ready  : convolver tile-valid level; a 0->1 transition captures
//   in_data   : tile, word k = y*PARA_X + x at [k*DATA_WIDTH +: DATA_WIDTH]
//   relu_en   : zero negative words (sign bit set) at capture
//   out_if    : valid/ready word stream with x/y/last tags
//   busy      : at least one bank holds a tile
//   overflow  : sticky, a tile arrived while its target bank was full
module conv_result_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PARA_X     = 3,
  parameter int unsigned PARA_Y     = 3,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] in_data,
  input  logic                                relu_en,
  conv_result_drain_if.master                 out_if,
  output logic                                busy,
  output logic                                overflow
);

  localparam int unsigned N  = PARA_X * PARA_Y;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0] mem_q [2][N];
  logic [DATA_WIDTH-1:0] cap_word [N];
  logic [1:0]            full_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic                  prev_ready_q;
  logic                  overflow_q;
  logic [KW-1:0]         k_q;
  logic [IDX_WIDTH-1:0]  x_q;
  logic [IDX_WIDTH-1:0]  y_q;

  logic capture;
  logic accept;
  logic drop;
  logic pop;
  logic pop_last;

  assign capture  = in_ready & ~prev_ready_q;
  // Full flags are the pre-edge values, so a bank freed on this same edge
  // still counts as full and the colliding tile is dropped.
  assign accept   = capture & ~full_q[wr_ptr_q];
  assign drop     = capture & full_q[wr_ptr_q];
  assign pop      = full_q[rd_ptr_q] & out_if.ready;
  assign pop_last = pop & (k_q == KW'(N - 1));

  // ReLU: any word with the sign bit set (incl. -0, -Inf, negative NaN) -> 0.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cap_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH]
                    & {DATA_WIDTH{~(relu_en & in_data[i*DATA_WIDTH + DATA_WIDTH - 1])}};
    end
  end

  // Bank storage carries no reset; contents only matter while full.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < int'(N); i++) begin
        mem_q[wr_ptr_q][i] <= cap_word[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      k_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      // Treat in_ready as already high so a tile held across reset is ignored.
      prev_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      prev_ready_q <= in_ready;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      // accept targets an empty bank, pop_last a full one: never the same bit.
      if (accept) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        if (pop_last) begin
          k_q              <= '0;
          x_q              <= '0;
          y_q              <= '0;
          full_q[rd_ptr_q] <= 1'b0;
          rd_ptr_q         <= ~rd_ptr_q;
        end else begin
          k_q <= k_q + 1'b1;
          if (x_q == IDX_WIDTH'(PARA_X - 1)) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
    end
  end

  assign out_if.valid = full_q[rd_ptr_q];
  assign out_if.data  = full_q[rd_ptr_q] ? mem_q[rd_ptr_q][k_q] : '0;
  assign out_if.x     = x_q;
  assign out_if.y     = y_q;
  assign out_if.last  = full_q[rd_ptr_q] & (k_q == KW'(N - 1));
  assign busy         = |full_q;
  assign overflow     = overflow_q;

endmodule
